// File: rtl/vga_pkg.sv
// Shared VGA timing types and default 800x600@60 mode constants.
// Imported by vga_axis_counter and vga_timing_param.
package vga_pkg;

   localparam int HOR_ACTIVE = 800;
   localparam int HOR_FP     = 40;
   localparam int HOR_SYNC   = 128;
   localparam int HOR_BP     = 88;

   localparam int VER_ACTIVE = 600;
   localparam int VER_FP     = 1;
   localparam int VER_SYNC   = 4;
   localparam int VER_BP     = 23;

   typedef logic [10:0] vga_cnt_t;

   typedef struct packed {
      int active;
      int fp;
      int sync;
      int bp;
   } vga_mode_t;

   function automatic int mode_total(vga_mode_t m);
      return m.active + m.fp + m.sync + m.bp;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter with registered blank/sync decode.
// Ports: clk, rst (sync, active-high), step -> count, blnk, sync, wrap.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACTIVE = HOR_ACTIVE,
   parameter int FP     = HOR_FP,
   parameter int SYNC   = HOR_SYNC,
   parameter int BP     = HOR_BP,
   parameter int POL    = 1,
   parameter int CW     = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          step,
   output logic [CW-1:0] count,
   output logic          blnk,
   output logic          sync,
   output logic          wrap
);

   localparam int TOTAL = ACTIVE + FP + SYNC + BP;

   localparam logic [CW-1:0] LAST_C = CW'(TOTAL - 1);
   localparam logic [CW-1:0] ACT_C  = CW'(ACTIVE);
   localparam logic [CW-1:0] SS_C   = CW'(ACTIVE + FP);
   localparam logic [CW-1:0] SE_C   = CW'(ACTIVE + FP + SYNC);
   localparam logic          ACT_LV = (POL != 0);

   logic [CW-1:0] count_q, count_d;
   logic          blnk_q, blnk_d;
   logic          sync_q, sync_d;

   // wrap looks at the current count so the other axis can step in
   // the same edge this one returns to zero.
   assign wrap = (count_q == LAST_C);

   // Decode from the next count so blank/sync line up with count.
   always_comb begin
      count_d = count_q;
      if (step) begin
         count_d = wrap ? '0 : count_q + 1'b1;
      end
      blnk_d = (count_d >= ACT_C);
      sync_d = ((count_d >= SS_C) && (count_d < SE_C)) ? ACT_LV : ~ACT_LV;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         blnk_q  <= 1'b0;
         sync_q  <= ~ACT_LV;
      end else begin
         count_q <= count_d;
         blnk_q  <= blnk_d;
         sync_q  <= sync_d;
      end
   end

   assign count = count_q;
   assign blnk  = blnk_q;
   assign sync  = sync_q;

endmodule

// File: rtl/vga_timing_param.sv
// Parametrised VGA timing: hcount/vcount, sync, blank, frame_start.
// Ports: pclk, rst, en -> hcount, vcount, hsync, vsync, hblnk, vblnk,
// frame_start; frame_cnt[15:0] when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_param
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = HOR_ACTIVE,
   parameter int H_FP     = HOR_FP,
   parameter int H_SYNC   = HOR_SYNC,
   parameter int H_BP     = HOR_BP,
   parameter int V_ACTIVE = VER_ACTIVE,
   parameter int V_FP     = VER_FP,
   parameter int V_SYNC   = VER_SYNC,
   parameter int V_BP     = VER_BP,
   parameter int HS_POL   = 1,
   parameter int VS_POL   = 1,
   parameter int CW       = 11
) (
   input  logic          pclk,
   input  logic          rst,
   input  logic          en,
   output logic [CW-1:0] hcount,
   output logic [CW-1:0] vcount,
   output logic          hsync,
   output logic          vsync,
   output logic          hblnk,
   output logic          vblnk,
   output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,
   output logic [15:0]   frame_cnt
`endif
);

   localparam vga_mode_t H_MODE = '{H_ACTIVE, H_FP, H_SYNC, H_BP};
   localparam vga_mode_t V_MODE = '{V_ACTIVE, V_FP, V_SYNC, V_BP};
   localparam int H_TOTAL = mode_total(H_MODE);
   localparam int V_TOTAL = mode_total(V_MODE);

   if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
       V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
      $error("vga_timing_param: porch/sync parameter is zero");
   end

   if ((64'd1 << CW) < 64'(H_TOTAL) ||
       (64'd1 << CW) < 64'(V_TOTAL)) begin : g_bad_cw
      $error("vga_timing_param: CW too small for mode");
   end

   logic h_wrap;
   logic v_wrap;
   logic v_step;

   assign v_step = en && h_wrap;

   vga_axis_counter #(
      .ACTIVE (H_MODE.active),
      .FP     (H_MODE.fp),
      .SYNC   (H_MODE.sync),
      .BP     (H_MODE.bp),
      .POL    (HS_POL),
      .CW     (CW)
   ) u_h (
      .clk   (pclk),
      .rst   (rst),
      .step  (en),
      .count (hcount),
      .blnk  (hblnk),
      .sync  (hsync),
      .wrap  (h_wrap)
   );

   vga_axis_counter #(
      .ACTIVE (V_MODE.active),
      .FP     (V_MODE.fp),
      .SYNC   (V_MODE.sync),
      .BP     (V_MODE.bp),
      .POL    (VS_POL),
      .CW     (CW)
   ) u_v (
      .clk   (pclk),
      .rst   (rst),
      .step  (v_step),
      .count (vcount),
      .blnk  (vblnk),
      .sync  (vsync),
      .wrap  (v_wrap)
   );

   logic frame_start_q, frame_start_d;
   logic frame_wrap;

   // Both axes at their last position: this edge lands on (0,0).
   assign frame_wrap = h_wrap && v_wrap;

   // Holds while disabled so the strobe spans exactly one enabled cycle.
   always_comb begin
      frame_start_d = frame_start_q;
      if (en) begin
         frame_start_d = frame_wrap;
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         frame_start_q <= 1'b0;
      end else begin
         frame_start_q <= frame_start_d;
      end
   end

   assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (en && frame_wrap) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         frame_cnt_q <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_param.sv
// Self-checking bench: three modes against a position-based model.
// Covers default, small negative-polarity and 640x480 negative-polarity.
module tb_vga_timing_param;

   typedef struct {
      int h;
      int v;
      bit hs;
      bit vs;
      bit hb;
      bit vb;
   } exp_t;

   localparam int TA = 1056 * 628;
   localparam int TB = 29 * 16;
   localparam int TC = 800 * 525;

   logic pclk = 1'b0;
   logic rst;
   logic en;

   always #5 pclk = ~pclk;

   logic [10:0] hc_a, vc_a;
   logic        hs_a, vs_a, hb_a, vb_a, fs_a;
   logic [4:0]  hc_b, vc_b;
   logic        hs_b, vs_b, hb_b, vb_b, fs_b;
   logic [9:0]  hc_c, vc_c;
   logic        hs_c, vs_c, hb_c, vb_c, fs_c;
   logic [15:0] fc_a, fc_b, fc_c;

`ifndef VGA_TIMING_FRAME_CNT_EN
   assign fc_a = '0;
   assign fc_b = '0;
   assign fc_c = '0;
`endif

   vga_timing_param dut_a (
      .pclk(pclk), .rst(rst), .en(en),
      .hcount(hc_a), .vcount(vc_a),
      .hsync(hs_a), .vsync(vs_a),
      .hblnk(hb_a), .vblnk(vb_a),
      .frame_start(fs_a)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_cnt(fc_a)
`endif
   );

   vga_timing_param #(
      .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(4),
      .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3),
      .HS_POL(0), .VS_POL(0), .CW(5)
   ) dut_b (
      .pclk(pclk), .rst(rst), .en(en),
      .hcount(hc_b), .vcount(vc_b),
      .hsync(hs_b), .vsync(vs_b),
      .hblnk(hb_b), .vblnk(vb_b),
      .frame_start(fs_b)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_cnt(fc_b)
`endif
   );

   vga_timing_param #(
      .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
      .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
      .HS_POL(0), .VS_POL(0), .CW(10)
   ) dut_c (
      .pclk(pclk), .rst(rst), .en(en),
      .hcount(hc_c), .vcount(vc_c),
      .hsync(hs_c), .vsync(vs_c),
      .hblnk(hb_c), .vblnk(vb_c),
      .frame_start(fs_c)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_cnt(fc_c)
`endif
   );

   // Model state: enabled steps since reset, modulo the frame length.
   int pa, pb, pc;
   bit fsa, fsb, fsc;
   int fca, fcb, fcc;

   always @(posedge pclk) begin
      if (rst) begin
         pa <= 0; pb <= 0; pc <= 0;
         fsa <= 0; fsb <= 0; fsc <= 0;
         fca <= 0; fcb <= 0; fcc <= 0;
      end else if (en) begin
         pa <= (pa + 1) % TA;
         pb <= (pb + 1) % TB;
         pc <= (pc + 1) % TC;
         fsa <= ((pa + 1) % TA == 0);
         fsb <= ((pb + 1) % TB == 0);
         fsc <= ((pc + 1) % TC == 0);
         if ((pa + 1) % TA == 0) fca <= (fca + 1) % 65536;
         if ((pb + 1) % TB == 0) fcb <= (fcb + 1) % 65536;
         if ((pc + 1) % TC == 0) fcc <= (fcc + 1) % 65536;
      end
   end

   function automatic exp_t model(int pos,
                                  int ha, int hf, int hs, int hb,
                                  int va, int vf, int vs, int vb,
                                  int hp, int vp);
      exp_t e;
      int   ht;
      ht   = ha + hf + hs + hb;
      e.h  = pos % ht;
      e.v  = pos / ht;
      e.hb = (e.h >= ha);
      e.vb = (e.v >= va);
      e.hs = (e.h >= ha + hf && e.h < ha + hf + hs) ? (hp != 0) : (hp == 0);
      e.vs = (e.v >= va + vf && e.v < va + vf + vs) ? (vp != 0) : (vp == 0);
      return e;
   endfunction

   int tests = 0;
   int fails = 0;

   task automatic cmp(string nm, exp_t e, bit fse, int fce,
                      int h, int v, bit hs, bit vs, bit hb, bit vb,
                      bit fs, int fc);
      bit bad;
      tests++;
      bad = (h != e.h) || (v != e.v) || (hs != e.hs) || (vs != e.vs) ||
            (hb != e.hb) || (vb != e.vb) || (fs != fse);
`ifdef VGA_TIMING_FRAME_CNT_EN
      bad = bad || (fc != fce);
`endif
      if (bad) begin
         fails++;
         $display("FAIL %s t=%0t got h=%0d v=%0d hs=%0b vs=%0b hb=%0b vb=%0b fs=%0b fc=%0d exp h=%0d v=%0d hs=%0b vs=%0b hb=%0b vb=%0b fs=%0b fc=%0d",
                  nm, $time, h, v, hs, vs, hb, vb, fs, fc,
                  e.h, e.v, e.hs, e.vs, e.hb, e.vb, fse, fce);
      end
   endtask

   task automatic chk(string nm, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge pclk);
      cmp("mode_a", model(pa, 800, 40, 128, 88, 600, 1, 4, 23, 1, 1),
          fsa, fca, int'(hc_a), int'(vc_a), hs_a, vs_a, hb_a, vb_a,
          fs_a, int'(fc_a));
      cmp("mode_b", model(pb, 20, 2, 3, 4, 10, 1, 2, 3, 0, 0),
          fsb, fcb, int'(hc_b), int'(vc_b), hs_b, vs_b, hb_b, vb_b,
          fs_b, int'(fc_b));
      cmp("mode_c", model(pc, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0),
          fsc, fcc, int'(hc_c), int'(vc_c), hs_c, vs_c, hb_c, vb_c,
          fs_c, int'(fc_c));
   endtask

   task automatic chk_reset_vals(string nm);
      chk({nm, "_hc_a"}, int'(hc_a), 0);
      chk({nm, "_vc_a"}, int'(vc_a), 0);
      chk({nm, "_hs_a"}, int'(hs_a), 0);
      chk({nm, "_vs_a"}, int'(vs_a), 0);
      chk({nm, "_hb_a"}, int'(hb_a), 0);
      chk({nm, "_fs_a"}, int'(fs_a), 0);
      chk({nm, "_hs_b"}, int'(hs_b), 1);
      chk({nm, "_vs_b"}, int'(vs_b), 1);
      chk({nm, "_vc_b"}, int'(vc_b), 0);
   endtask

   initial begin
      bit found;
      rst = 1'b1;
      en  = 1'b1;
      repeat (5) tick();
      chk_reset_vals("in_reset");

      rst = 1'b0;
      for (int i = 1; i <= 2200; i++) begin
         tick();
         if (i == 1) begin
            chk("first_h", int'(hc_a), 1);
            chk("first_v", int'(vc_a), 0);
            chk("first_hs", int'(hs_a), 0);
            chk("first_vs", int'(vs_a), 0);
            chk("first_blnk", int'(hb_a | vb_a), 0);
         end
         if (i == 799)  chk("hb_799", int'(hb_a), 0);
         if (i == 800)  chk("hb_800", int'(hb_a), 1);
         if (i == 839)  chk("hs_839", int'(hs_a), 0);
         if (i == 840)  chk("hs_840", int'(hs_a), 1);
         if (i == 967)  chk("hs_967", int'(hs_a), 1);
         if (i == 968)  chk("hs_968", int'(hs_a), 0);
         if (i == 1055) chk("h_1055", int'(hc_a), 1055);
         if (i == 1056) begin
            chk("wrap_h", int'(hc_a), 0);
            chk("wrap_v", int'(vc_a), 1);
            chk("wrap_hb", int'(hb_a), 0);
         end
         if (i == 318) chk("b_vs_318", int'(vs_b), 1);
         if (i == 319) begin
            chk("b_v_319", int'(vc_b), 11);
            chk("b_vs_319", int'(vs_b), 0);
         end
         if (i == 377) chk("b_vs_377", int'(vs_b), 1);
         if (i == 463) chk("b_fs_463", int'(fs_b), 0);
         if (i == 464) begin
            chk("b_fs_464", int'(fs_b), 1);
            chk("b_hv_464", int'(hc_b) + int'(vc_b), 0);
         end
         if (i == 465) chk("b_fs_465", int'(fs_b), 0);
         if (i == 655) chk("c_hs_655", int'(hs_c), 1);
         if (i == 656) chk("c_hs_656", int'(hs_c), 0);
         if (i == 751) chk("c_hs_751", int'(hs_c), 0);
         if (i == 752) chk("c_hs_752", int'(hs_c), 1);
      end

      for (int i = 0; i < 2000; i++) begin
         en = i[0];
         tick();
      end
      for (int i = 0; i < 3000; i++) begin
         en = 1'($urandom_range(0, 1));
         tick();
      end

      en = 1'b1;
      found = 0;
      for (int i = 0; i < 1200 && !found; i++) begin
         tick();
         if (hc_a == 11'd900) found = 1;
      end
      chk("wait_h900", int'(found), 1);
      rst = 1'b1;
      en  = 1'b0;
      tick();
      chk_reset_vals("rst_a");
      rst = 1'b0;
      en  = 1'b1;

      found = 0;
      for (int i = 0; i < 600 && !found; i++) begin
         tick();
         if (vc_b == 5'd11 && hc_b == 5'd23) found = 1;
      end
      chk("wait_b_sync", int'(found), 1);
      chk("b_sync_act", int'(hs_b | vs_b), 0);
      rst = 1'b1;
      tick();
      chk_reset_vals("rst_b");
      rst = 1'b0;

      for (int i = 0; i < 1500; i++) begin
         en = 1'($urandom_range(0, 3) != 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
